btn_event: RTL

BTN_EVENT -- requirements
Module: btn_event

---
 rtl/btn_event.sv | 118 +++++++++++
 1 files changed

// File: rtl/btn_event.sv
// btn_event: turns a debounced button level into press / release /
// long-press / auto-repeat event pulses plus a registered "held" level.
// Every output comes straight from a flop.
// Pulses are one clock wide and mutually exclusive.
// A release seen at the same edge as a terminal count wins over it.
module btn_event #(
    parameter int LONG_CYCLES   = 10_000_000,
    parameter int REPEAT_CYCLES = 2_500_000,
    parameter int CNT_W         = 24
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_level,
    output logic press,
    output logic release_pulse,
    output logic long_press,
    output logic repeat_pulse,
    output logic held
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        PRESS = 2'b01,
        LONG  = 2'b10
    } state_t;

    // Terminal counts: the counter runs 0..N-1, so an event lands N cycles
    // after the previous one.
    localparam logic [CNT_W-1:0] LONG_TERM   = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_TERM = CNT_W'(REPEAT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_r;
    state_t           state_next_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_next_s;
    logic             press_next_s;
    logic             release_next_s;
    logic             long_next_s;
    logic             repeat_next_s;
    logic             held_next_s;

    // Next-state, next-count and next-pulse decode for the hold tracker.
    always_comb begin
        state_next_s   = state_r;
        cnt_next_s     = cnt_r;
        press_next_s   = 1'b0;
        release_next_s = 1'b0;
        long_next_s    = 1'b0;
        repeat_next_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (btn_level) begin
                    state_next_s = PRESS;
                    cnt_next_s   = CNT_ZERO;
                    press_next_s = 1'b1;
                end else begin
                    cnt_next_s   = CNT_ZERO;
                end
            end
            PRESS: begin
                if (!btn_level) begin
                    // Release takes priority over a coincident terminal count.
                    state_next_s   = IDLE;
                    cnt_next_s     = CNT_ZERO;
                    release_next_s = 1'b1;
                end else if (cnt_r == LONG_TERM) begin
                    state_next_s = LONG;
                    cnt_next_s   = CNT_ZERO;
                    long_next_s  = 1'b1;
                end else begin
                    cnt_next_s   = cnt_r + CNT_ONE;
                end
            end
            LONG: begin
                if (!btn_level) begin
                    state_next_s   = IDLE;
                    cnt_next_s     = CNT_ZERO;
                    release_next_s = 1'b1;
                end else if (cnt_r == REPEAT_TERM) begin
                    cnt_next_s    = CNT_ZERO;
                    repeat_next_s = 1'b1;
                end else begin
                    cnt_next_s    = cnt_r + CNT_ONE;
                end
            end
            default: begin
                // Illegal encoding: fall back to IDLE silently.
                state_next_s = IDLE;
                cnt_next_s   = CNT_ZERO;
            end
        endcase
        held_next_s = (state_next_s != IDLE);
    end

    // State, counter and registered outputs; async reset clears everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= IDLE;
            cnt_r         <= CNT_ZERO;
            press         <= 1'b0;
            release_pulse <= 1'b0;
            long_press    <= 1'b0;
            repeat_pulse  <= 1'b0;
            held          <= 1'b0;
        end else begin
            state_r       <= state_next_s;
            cnt_r         <= cnt_next_s;
            press         <= press_next_s;
            release_pulse <= release_next_s;
            long_press    <= long_next_s;
            repeat_pulse  <= repeat_next_s;
            held          <= held_next_s;
        end
    end

endmodule
